// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions: the scoreboard slot record, the
// "read from register file" forward code and default pipeline sizes.
package pipe_pkg;

  // Default pipeline sizing reused by the pipeline top.
  localparam int DEF_NREG  = 32;
  localparam int DEF_DEPTH = 3;

  // Register index field in a slot is sized for up to 256 registers;
  // narrower register files zero-extend their indices into it.
  localparam int MAX_RW = 8;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // One tracked post-decode stage: valid writer, destination, is-a-load.
  typedef struct packed {
    logic              v;
    logic [MAX_RW-1:0] rd;
    logic              ld;
  } slot_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Youngest-match priority encoder: finds the lowest-index slot whose
// destination equals the requested source register.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int SW    = $clog2(DEPTH + 1)
) (
  input  slot_t [DEPTH:1]    slots,
  input  logic               en,
  input  logic [MAX_RW-1:0]  src,
  output logic               hit,
  output logic [SW-1:0]      idx,
  output logic               ld
);

  // Scan oldest to youngest so the youngest match overwrites older ones;
  // register 0 never produces a match.
  always_comb begin
    hit = 1'b0;
    idx = SW'(FWD_RF);
    ld  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (en && (src != '0) && slots[k].v && (slots[k].rd == src)) begin
        hit = 1'b1;
        idx = SW'(k);
        ld  = slots[k].ld;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard scoreboard: tracks in-flight destinations across
// DEPTH post-decode stages, raises load-use stalls and picks forward sources.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG       = DEF_NREG,
  parameter int RW         = $clog2(NREG),
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_READY = 2,
  parameter int SW         = $clog2(DEPTH + 1),
  parameter int CW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_wr,
  input  logic          id_load,
  input  logic          ex_flush,
  output logic          stall,
  output logic [SW-1:0] fwd_a,
  output logic [SW-1:0] fwd_b,
  output logic [CW-1:0] stall_cnt
);

  slot_t [DEPTH:1] slots_q, slots_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;

  logic            hit_a, hit_b, ld_a, ld_b;
  logic [SW-1:0]   idx_a, idx_b;
  logic            haz_a, haz_b;

  hazard_match #(.DEPTH(DEPTH), .SW(SW)) u_match_a (
    .slots (slots_q),
    .en    (id_valid && id_use_rs),
    .src   (MAX_RW'(id_rs)),
    .hit   (hit_a),
    .idx   (idx_a),
    .ld    (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH), .SW(SW)) u_match_b (
    .slots (slots_q),
    .en    (id_valid && id_use_rt),
    .src   (MAX_RW'(id_rt)),
    .hit   (hit_b),
    .idx   (idx_b),
    .ld    (ld_b)
  );

  // A load result is not forwardable until it reaches LOAD_READY; a younger
  // match on a load stalls decode and the select is parked on the RF.
  always_comb begin
    haz_a = hit_a && ld_a && (idx_a < SW'(LOAD_READY));
    haz_b = hit_b && ld_b && (idx_b < SW'(LOAD_READY));
    stall = haz_a || haz_b;
    fwd_a = (hit_a && !haz_a) ? idx_a : SW'(FWD_RF);
    fwd_b = (hit_b && !haz_b) ? idx_b : SW'(FWD_RF);
  end

  // Next slot state: everything shifts one stage older, the oldest retires,
  // and slot 1 takes the decoding instruction unless stalled or flushed.
  always_comb begin
    slots_d = slots_q;
    for (int k = DEPTH; k >= 2; k--) begin
      slots_d[k] = slots_q[k-1];
    end
    slots_d[1].v  = id_valid && id_wr && !stall && !ex_flush;
    slots_d[1].rd = MAX_RW'(id_rd);
    slots_d[1].ld = id_load;
  end

  // Stall counter saturates at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  // Register update; reset drops every in-flight entry and the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
